snake_step_ctrl: RTL

//  Game-step sequencer for the snake playfield. Owns the grid's single-port cell RAM (WIDTH x HEIGHT lifetime counters;
//  a cell holds a snake segment when its value is non-zero). On each refresh tick it sweeps and decrements the grid.
//  It then moves the head and checks for wall, self and food hits. It grows the snake and places new food.

---
 rtl/snake_step_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game-step sequencer for the snake playfield.
// Owns the grid cell RAM port (lifetime counters, non-zero = body segment),
// clears and seeds the grid, sweeps/decrements it on each refresh tick,
// moves the head, detects wall/self/food hits and places new food.
module snake_step_ctrl #(
  parameter int WIDTH    = 30,
  parameter int HEIGHT   = 22,
  parameter int LEN_W    = 10,
  parameter int INIT_LEN = 5,
  parameter int START_X  = 15,
  parameter int START_Y  = 10
) (
  input  logic             vga_clock,
  input  logic             rst_n,
  input  logic             refresh,
  input  logic             up_in,
  input  logic             down_in,
  input  logic             left_in,
  input  logic             right_in,
  input  logic             restart_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [4:0]       mem_x,
  output logic [4:0]       mem_y,
  output logic [LEN_W-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic [LEN_W-1:0] mem_rdata,
  output logic [4:0]       food_x,
  output logic [4:0]       food_y,
  output logic [LEN_W-1:0] length,
  output logic             dead,
  output logic             busy,
  output logic             step_done,
  output logic             tick_miss
);

  typedef enum logic [2:0] {
    S_CLEAR, S_INIT_HEAD, S_FOOD, S_IDLE, S_SWEEP, S_HEAD, S_DEAD
  } state_t;

  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

  localparam logic [4:0]       X_LAST   = 5'(WIDTH - 1);
  localparam logic [4:0]       Y_LAST   = 5'(HEIGHT - 1);
  localparam logic [5:0]       WIDTH6   = 6'(WIDTH);
  localparam logic [5:0]       HEIGHT6  = 6'(HEIGHT);
  localparam logic [4:0]       X_START  = 5'(START_X);
  localparam logic [4:0]       Y_START  = 5'(START_Y);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
  localparam logic [9:0]       LFSR_SEED = 10'h3FF;

  // Fibonacci LFSR for x^10 + x^7 + 1.
  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  // True when b points the opposite way to a.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    logic r;
    case (a)
      D_RIGHT: r = (b == D_LEFT);
      D_LEFT:  r = (b == D_RIGHT);
      D_UP:    r = (b == D_DOWN);
      D_DOWN:  r = (b == D_UP);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r, state_s;
  dir_t             dir_r, dir_s, next_dir_r, next_dir_s, btn_dir_s;
  logic             btn_valid_s;
  logic [4:0]       head_x_r, head_x_s, head_y_r, head_y_s;
  logic [4:0]       nx_r, nx_s, ny_r, ny_s;
  logic [4:0]       cx_r, cx_s, cy_r, cy_s, cx_inc_s, cy_inc_s;
  logic             cur_last_s, sweep_adv_s, wall_s, edge_s;
  logic [4:0]       step_x_s, step_y_s;
  logic             rd_pend_r, rd_pend_s, grow_pend_r, grow_pend_s;
  logic             refresh_q_r;
  logic [9:0]       lfsr_r, lfsr_s;
  logic [LEN_W-1:0] len_inc_s;
  logic             mem_req_s, mem_we_s, dead_s, busy_s, step_done_s, tick_miss_s;
  logic [4:0]       mem_x_s, mem_y_s, food_x_s, food_y_s;
  logic [LEN_W-1:0] mem_wdata_s, length_s;

  // Raster cursor helpers, direction decode and head-step arithmetic.
  always_comb begin
    cur_last_s = (cx_r == X_LAST) && (cy_r == Y_LAST);
    if (cx_r == X_LAST) begin
      cx_inc_s = 5'd0;
      cy_inc_s = cy_r + 5'd1;
    end else begin
      cx_inc_s = cx_r + 5'd1;
      cy_inc_s = cy_r;
    end
    btn_valid_s = 1'b1;
    if (up_in) begin
      btn_dir_s = D_UP;
    end else if (down_in) begin
      btn_dir_s = D_DOWN;
    end else if (left_in) begin
      btn_dir_s = D_LEFT;
    end else if (right_in) begin
      btn_dir_s = D_RIGHT;
    end else begin
      btn_dir_s   = D_RIGHT;
      btn_valid_s = 1'b0;
    end
    step_x_s = head_x_r;
    step_y_s = head_y_r;
    wall_s   = 1'b0;
    case (next_dir_r)
      D_RIGHT: begin wall_s = (head_x_r == X_LAST); step_x_s = head_x_r + 5'd1; end
      D_LEFT:  begin wall_s = (head_x_r == 5'd0);   step_x_s = head_x_r - 5'd1; end
      D_UP:    begin wall_s = (head_y_r == 5'd0);   step_y_s = head_y_r - 5'd1; end
      D_DOWN:  begin wall_s = (head_y_r == Y_LAST); step_y_s = head_y_r + 5'd1; end
      default: begin wall_s = 1'b1; end
    endcase
    len_inc_s = (length == LEN_MAX) ? length : (length + LEN_ONE);
    edge_s    = refresh & ~refresh_q_r;
  end

  // Next-state and next-output logic for the step sequencer.
  always_comb begin
    state_s     = state_r;
    dir_s       = dir_r;
    next_dir_s  = next_dir_r;
    head_x_s    = head_x_r;
    head_y_s    = head_y_r;
    nx_s        = nx_r;
    ny_s        = ny_r;
    cx_s        = cx_r;
    cy_s        = cy_r;
    rd_pend_s   = rd_pend_r;
    grow_pend_s = grow_pend_r;
    lfsr_s      = lfsr_r;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_x_s     = mem_x;
    mem_y_s     = mem_y;
    mem_wdata_s = mem_wdata;
    food_x_s    = food_x;
    food_y_s    = food_y;
    length_s    = length;
    dead_s      = dead;
    step_done_s = 1'b0;
    tick_miss_s = 1'b0;
    sweep_adv_s = 1'b0;

    if (btn_valid_s && !is_opposite(dir_r, btn_dir_s)) begin
      next_dir_s = btn_dir_s;
    end else begin
      next_dir_s = next_dir_r;
    end

    if (edge_s && (state_r != S_IDLE) && (state_r != S_DEAD)) begin
      tick_miss_s = 1'b1;
    end else begin
      tick_miss_s = 1'b0;
    end

    case (state_r)
      S_CLEAR: begin
        if (!mem_req) begin
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b1;
          mem_x_s     = cx_r;
          mem_y_s     = cy_r;
          mem_wdata_s = LEN_ZERO;
        end else if (mem_gnt) begin
          if (cur_last_s) begin
            mem_req_s = 1'b0;
            cx_s      = 5'd0;
            cy_s      = 5'd0;
            state_s   = S_INIT_HEAD;
          end else begin
            // Keep the request up and move straight to the next cell.
            cx_s    = cx_inc_s;
            cy_s    = cy_inc_s;
            mem_x_s = cx_inc_s;
            mem_y_s = cy_inc_s;
          end
        end else begin
          mem_req_s = 1'b1;
        end
      end
      S_INIT_HEAD: begin
        if (!mem_req) begin
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b1;
          mem_x_s     = X_START;
          mem_y_s     = Y_START;
          mem_wdata_s = LEN_INIT;
        end else if (mem_gnt) begin
          mem_req_s = 1'b0;
          state_s   = S_FOOD;
        end else begin
          mem_req_s = 1'b1;
        end
      end
      S_FOOD: begin
        lfsr_s = lfsr_step(lfsr_r);
        if (rd_pend_r) begin
          rd_pend_s = 1'b0;
          if (mem_rdata == LEN_ZERO) begin
            food_x_s    = mem_x;
            food_y_s    = mem_y;
            state_s     = S_IDLE;
            step_done_s = 1'b1;
          end else begin
            state_s = S_FOOD;
          end
        end else if (mem_req) begin
          if (mem_gnt) begin
            mem_req_s = 1'b0;
            rd_pend_s = 1'b1;
          end else begin
            mem_req_s = 1'b1;
          end
        end else if (({1'b0, lfsr_r[4:0]} < WIDTH6) && ({1'b0, lfsr_r[9:5]} < HEIGHT6)) begin
          mem_req_s = 1'b1;
          mem_we_s  = 1'b0;
          mem_x_s   = lfsr_r[4:0];
          mem_y_s   = lfsr_r[9:5];
        end else begin
          state_s = S_FOOD;
        end
      end
      S_IDLE: begin
        if (edge_s) begin
          dir_s = next_dir_r;
          if (wall_s) begin
            dead_s      = 1'b1;
            step_done_s = 1'b1;
            state_s     = S_DEAD;
          end else begin
            nx_s = step_x_s;
            ny_s = step_y_s;
            cx_s = 5'd0;
            cy_s = 5'd0;
            if (grow_pend_r) begin
              grow_pend_s = 1'b0;
              state_s     = S_HEAD;
            end else begin
              state_s = S_SWEEP;
            end
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (rd_pend_r) begin
          rd_pend_s = 1'b0;
          if (mem_rdata != LEN_ZERO) begin
            mem_req_s   = 1'b1;
            mem_we_s    = 1'b1;
            mem_wdata_s = mem_rdata - LEN_ONE;
          end else begin
            sweep_adv_s = 1'b1;
          end
        end else if (mem_req) begin
          if (mem_gnt) begin
            if (mem_we) begin
              mem_req_s   = 1'b0;
              sweep_adv_s = 1'b1;
            end else begin
              mem_req_s = 1'b0;
              rd_pend_s = 1'b1;
            end
          end else begin
            mem_req_s = 1'b1;
          end
        end else begin
          mem_req_s = 1'b1;
          mem_we_s  = 1'b0;
          mem_x_s   = cx_r;
          mem_y_s   = cy_r;
        end
        // Finished with the current cell: chain the next read or move on.
        if (sweep_adv_s) begin
          if (cur_last_s) begin
            mem_req_s = 1'b0;
            cx_s      = 5'd0;
            cy_s      = 5'd0;
            state_s   = S_HEAD;
          end else begin
            cx_s      = cx_inc_s;
            cy_s      = cy_inc_s;
            mem_req_s = 1'b1;
            mem_we_s  = 1'b0;
            mem_x_s   = cx_inc_s;
            mem_y_s   = cy_inc_s;
          end
        end else begin
          cx_s = cx_s;
        end
      end
      S_HEAD: begin
        if (rd_pend_r) begin
          rd_pend_s = 1'b0;
          if (mem_rdata != LEN_ZERO) begin
            dead_s      = 1'b1;
            step_done_s = 1'b1;
            state_s     = S_DEAD;
          end else if ((nx_r == food_x) && (ny_r == food_y)) begin
            length_s    = len_inc_s;
            grow_pend_s = 1'b1;
            mem_req_s   = 1'b1;
            mem_we_s    = 1'b1;
            mem_wdata_s = len_inc_s;
          end else begin
            mem_req_s   = 1'b1;
            mem_we_s    = 1'b1;
            mem_wdata_s = length;
          end
        end else if (mem_req) begin
          if (mem_gnt) begin
            mem_req_s = 1'b0;
            if (mem_we) begin
              head_x_s = nx_r;
              head_y_s = ny_r;
              if (grow_pend_r) begin
                state_s = S_FOOD;
              end else begin
                state_s     = S_IDLE;
                step_done_s = 1'b1;
              end
            end else begin
              rd_pend_s = 1'b1;
            end
          end else begin
            mem_req_s = 1'b1;
          end
        end else begin
          mem_req_s = 1'b1;
          mem_we_s  = 1'b0;
          mem_x_s   = nx_r;
          mem_y_s   = ny_r;
        end
      end
      S_DEAD: begin
        mem_req_s = 1'b0;
        rd_pend_s = 1'b0;
        if (restart_in) begin
          state_s     = S_CLEAR;
          dead_s      = 1'b0;
          length_s    = LEN_INIT;
          head_x_s    = X_START;
          head_y_s    = Y_START;
          dir_s       = D_RIGHT;
          next_dir_s  = D_RIGHT;
          grow_pend_s = 1'b0;
          cx_s        = 5'd0;
          cy_s        = 5'd0;
        end else begin
          state_s = S_DEAD;
        end
      end
      default: begin
        state_s   = S_CLEAR;
        mem_req_s = 1'b0;
        rd_pend_s = 1'b0;
        cx_s      = 5'd0;
        cy_s      = 5'd0;
      end
    endcase

    busy_s = (state_s != S_IDLE) && (state_s != S_DEAD);
  end

  // State and registered outputs; async reset abandons any access in flight.
  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_CLEAR;
      dir_r       <= D_RIGHT;
      next_dir_r  <= D_RIGHT;
      head_x_r    <= X_START;
      head_y_r    <= Y_START;
      nx_r        <= X_START;
      ny_r        <= Y_START;
      cx_r        <= 5'd0;
      cy_r        <= 5'd0;
      rd_pend_r   <= 1'b0;
      grow_pend_r <= 1'b0;
      refresh_q_r <= 1'b0;
      lfsr_r      <= LFSR_SEED;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_x       <= 5'd0;
      mem_y       <= 5'd0;
      mem_wdata   <= LEN_ZERO;
      food_x      <= 5'd0;
      food_y      <= 5'd0;
      length      <= LEN_INIT;
      dead        <= 1'b0;
      busy        <= 1'b1;
      step_done   <= 1'b0;
      tick_miss   <= 1'b0;
    end else begin
      state_r     <= state_s;
      dir_r       <= dir_s;
      next_dir_r  <= next_dir_s;
      head_x_r    <= head_x_s;
      head_y_r    <= head_y_s;
      nx_r        <= nx_s;
      ny_r        <= ny_s;
      cx_r        <= cx_s;
      cy_r        <= cy_s;
      rd_pend_r   <= rd_pend_s;
      grow_pend_r <= grow_pend_s;
      refresh_q_r <= refresh;
      lfsr_r      <= lfsr_s;
      mem_req     <= mem_req_s;
      mem_we      <= mem_we_s;
      mem_x       <= mem_x_s;
      mem_y       <= mem_y_s;
      mem_wdata   <= mem_wdata_s;
      food_x      <= food_x_s;
      food_y      <= food_y_s;
      length      <= length_s;
      dead        <= dead_s;
      busy        <= busy_s;
      step_done   <= step_done_s;
      tick_miss   <= tick_miss_s;
    end
  end

endmodule
